// File: rtl/lsu_ld_ctrl.sv
// LSU load controller: issues one strided multi-row AXI read request per command and
// streams the returned beats into the local load buffer at consecutive word addresses.
module lsu_ld_ctrl #(
  parameter int unsigned ARID_WIDTH   = 4,
  parameter int unsigned ARADDR_WIDTH = 10,
  parameter int unsigned RDATA_WIDTH  = 64,
  parameter int unsigned BUF_AW       = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic [ARADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_str,
  input  logic [3:0]              cmd_num,
  input  logic [BUF_AW-1:0]       cmd_dst,
  output logic [ARID_WIDTH-1:0]   lsu_axi_arid,
  output logic [ARADDR_WIDTH-1:0] lsu_axi_araddr,
  output logic [7:0]              lsu_axi_arlen,
  output logic [2:0]              lsu_axi_arsize,
  output logic [1:0]              lsu_axi_arburst,
  output logic [2:0]              lsu_axi_arstr,
  output logic [3:0]              lsu_axi_arnum,
  output logic                    lsu_axi_arvld,
  input  logic                    axi_lsu_arrdy,
  input  logic [ARID_WIDTH-1:0]   axi_lsu_rid,
  input  logic [RDATA_WIDTH-1:0]  axi_lsu_rdata,
  input  logic [1:0]              axi_lsu_rresp,
  input  logic                    axi_lsu_rlast,
  input  logic                    axi_lsu_rvld,
  output logic                    lsu_axi_rrdy,
  output logic                    buf_wen,
  output logic [BUF_AW-1:0]       buf_waddr,
  output logic [RDATA_WIDTH-1:0]  buf_wdata,
  output logic                    ld_busy,
  output logic                    ld_done,
  output logic                    ld_err
);

  localparam logic [2:0] ArSize = 3'($clog2(RDATA_WIDTH / 8));

  typedef enum logic [1:0] {StIdle, StReq, StRecv, StDone} state_e;

  state_e                  state_q;
  logic [ARADDR_WIDTH-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              str_q;
  logic [3:0]              num_q;
  logic [BUF_AW-1:0]       dst_q;
  logic [ARID_WIDTH-1:0]   arid_q;
  logic [BUF_AW-1:0]       beat_cnt_q;
  logic [3:0]              row_cnt_q;
  logic                    err_q;
  logic                    buf_wen_q;
  logic [BUF_AW-1:0]       buf_waddr_q;
  logic [RDATA_WIDTH-1:0]  buf_wdata_q;
  logic                    unused_rid;

  // Beat ID is not needed: only one request is ever outstanding.
  assign unused_rid = ^axi_lsu_rid;

  assign cmd_rdy         = (state_q == StIdle);
  assign ld_busy         = (state_q != StIdle);
  assign ld_done         = (state_q == StDone);
  assign ld_err          = err_q;
  assign lsu_axi_arvld   = (state_q == StReq);
  assign lsu_axi_rrdy    = (state_q == StRecv);
  assign lsu_axi_arid    = arid_q;
  assign lsu_axi_araddr  = addr_q;
  assign lsu_axi_arlen   = len_q;
  assign lsu_axi_arsize  = ArSize;
  assign lsu_axi_arburst = 2'b01;
  assign lsu_axi_arstr   = str_q;
  assign lsu_axi_arnum   = num_q;
  assign buf_wen         = buf_wen_q;
  assign buf_waddr       = buf_waddr_q;
  assign buf_wdata       = buf_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      str_q       <= '0;
      num_q       <= '0;
      dst_q       <= '0;
      arid_q      <= '0;
      beat_cnt_q  <= '0;
      row_cnt_q   <= '0;
      err_q       <= 1'b0;
      buf_wen_q   <= 1'b0;
      buf_waddr_q <= '0;
      buf_wdata_q <= '0;
    end else begin
      buf_wen_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_vld) begin
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            str_q      <= cmd_str;
            num_q      <= cmd_num;
            dst_q      <= cmd_dst;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            state_q    <= (cmd_num == 4'd0) ? StDone : StReq;
          end
        end
        StReq: begin
          if (axi_lsu_arrdy) begin
            arid_q  <= arid_q + ARID_WIDTH'(1);
            state_q <= StRecv;
          end
        end
        StRecv: begin
          if (axi_lsu_rvld) begin
            buf_wen_q   <= 1'b1;
            buf_waddr_q <= dst_q + beat_cnt_q;
            buf_wdata_q <= axi_lsu_rdata;
            beat_cnt_q  <= beat_cnt_q + BUF_AW'(1);
            if (axi_lsu_rresp != 2'b00) err_q <= 1'b1;
            // Only rlast advances rows; beat count is never compared against len.
            if (axi_lsu_rlast) begin
              row_cnt_q <= row_cnt_q + 4'd1;
              if ((row_cnt_q + 4'd1) == num_q) state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ld_ctrl.sv
// Scoreboard bench for lsu_ld_ctrl: stimulus pushes expected AR requests and buffer writes,
// a negedge monitor pops and compares them as the controller produces them.
module tb_lsu_ld_ctrl;
  localparam int IW = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 6;

  logic          clk, rst_n;
  logic          cmd_vld, cmd_rdy;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_str;
  logic [3:0]    cmd_num;
  logic [BW-1:0] cmd_dst;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arstr;
  logic [1:0]    arburst;
  logic [3:0]    arnum;
  logic          arvld, arrdy;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvld, rrdy;
  logic          buf_wen;
  logic [BW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic          ld_busy, ld_done, ld_err;

  lsu_ld_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_str        (cmd_str),
    .cmd_num        (cmd_num),
    .cmd_dst        (cmd_dst),
    .lsu_axi_arid   (arid),
    .lsu_axi_araddr (araddr),
    .lsu_axi_arlen  (arlen),
    .lsu_axi_arsize (arsize),
    .lsu_axi_arburst(arburst),
    .lsu_axi_arstr  (arstr),
    .lsu_axi_arnum  (arnum),
    .lsu_axi_arvld  (arvld),
    .axi_lsu_arrdy  (arrdy),
    .axi_lsu_rid    (rid),
    .axi_lsu_rdata  (rdata),
    .axi_lsu_rresp  (rresp),
    .axi_lsu_rlast  (rlast),
    .axi_lsu_rvld   (rvld),
    .lsu_axi_rrdy   (rrdy),
    .buf_wen        (buf_wen),
    .buf_waddr      (buf_waddr),
    .buf_wdata      (buf_wdata),
    .ld_busy        (ld_busy),
    .ld_done        (ld_done),
    .ld_err         (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            wen;
    logic [BW-1:0] addr;
    logic [DW-1:0] data;
    bit            done;
    bit            err;
  } wr_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    str;
    logic [3:0]    num;
  } ar_t;

  wr_t exp_wr[$];
  ar_t exp_ar[$];
  bit  exp_err_hold;
  int  arid_model;
  int  n_chk;
  int  n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    ar_t a;
    wr_t e;
    if (rst_n) begin
      if (arvld) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", arvld, 0);
        else begin
          a = exp_ar[0];
          chk("arid", arid, a.id);
          chk("araddr", araddr, a.addr);
          chk("arlen", arlen, a.len);
          chk("arstr", arstr, a.str);
          chk("arnum", arnum, a.num);
          chk("arsize", arsize, 3);
          chk("arburst", arburst, 1);
          if (arrdy) void'(exp_ar.pop_front());
        end
      end
      if (buf_wen || ld_done) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", {buf_wen, ld_done}, 0);
        else begin
          e = exp_wr.pop_front();
          chk("buf_wen", buf_wen, e.wen);
          if (e.wen) begin
            chk("buf_waddr", buf_waddr, e.addr);
            chk("buf_wdata", buf_wdata, e.data);
          end
          chk("ld_done", ld_done, e.done);
          if (e.done) begin
            chk("ld_err_done", ld_err, e.err);
            exp_err_hold = e.err;
          end
        end
      end else if (!ld_busy) begin
        chk("ld_err_idle", ld_err, exp_err_hold);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_arvld", arvld, 0);
    chk("rst_arid", arid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rrdy", rrdy, 0);
    chk("rst_buf_wen", buf_wen, 0);
    chk("rst_buf_waddr", buf_waddr, 0);
    chk("rst_buf_wdata", buf_wdata, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_ld_err", ld_err, 0);
  endtask

  task automatic idle_inputs();
    cmd_vld = 0; cmd_addr = '0; cmd_len = '0; cmd_str = '0; cmd_num = '0; cmd_dst = '0;
    arrdy = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvld = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    exp_wr.delete();
    exp_ar.delete();
    arid_model   = 0;
    exp_err_hold = 0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // gap_mode: 0 back-to-back beats, 1 one idle cycle before each beat, 2 random gaps.
  // abort_at >= 0 asserts reset once that many beats have been written.
  task automatic run_cmd(input logic [AW-1:0] addr, input int len, input int str, input int num,
                         input logic [BW-1:0] dst, input int ar_dly, input int gap_mode,
                         input int err_idx, input bit err_rand, input int abort_at);
    int            guard;
    int            total;
    int            gap;
    bit            err_acc;
    bit            e;
    logic [DW-1:0] d[$];
    bit            rs[$];
    wr_t           w;
    ar_t           a;

    guard = 0;
    while (!cmd_rdy && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("cmd_rdy_wait", cmd_rdy, 1);

    total   = (len + 1) * num;
    err_acc = 0;
    for (int i = 0; i < total; i++) begin
      d.push_back({$urandom, $urandom});
      e = err_rand ? ($urandom_range(0, 7) == 0) : (i == err_idx);
      rs.push_back(e);
      err_acc = err_acc | e;
      w.wen  = 1;
      w.addr = BW'(int'(dst) + i);
      w.data = d[i];
      w.done = (i == total - 1);
      w.err  = err_acc;
      exp_wr.push_back(w);
    end
    if (num == 0) begin
      w.wen = 0; w.addr = '0; w.data = '0; w.done = 1; w.err = 0;
      exp_wr.push_back(w);
    end else begin
      a.id   = IW'(arid_model);
      a.addr = addr;
      a.len  = 8'(len);
      a.str  = 3'(str);
      a.num  = 4'(num);
      exp_ar.push_back(a);
      arid_model = (arid_model + 1) % 16;
    end

    cmd_vld = 1; cmd_addr = addr; cmd_len = 8'(len); cmd_str = 3'(str);
    cmd_num = 4'(num); cmd_dst = dst;
    @(posedge clk);
    #1;
    cmd_vld = 0;
    if (num == 0) return;

    repeat (ar_dly) begin
      @(posedge clk);
      #1;
    end
    arrdy = 1;
    @(posedge clk);
    #1;
    arrdy = 0;

    for (int i = 0; i < total; i++) begin
      if (i == abort_at) begin
        rvld = 0;
        @(negedge clk);
        #1;
        apply_reset();
        return;
      end
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        rvld = 0;
        @(posedge clk);
        #1;
      end
      rvld  = 1;
      rdata = d[i];
      rresp = rs[i] ? 2'(2 + $urandom_range(0, 1)) : 2'b00;
      rlast = ((i % (len + 1)) == len);
      rid   = IW'($urandom);
      guard = 0;
      while (!rrdy && guard < 50) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("rrdy_wait", rrdy, 1);
      @(posedge clk);
      #1;
    end
    rvld  = 0;
    rlast = 0;
    rresp = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 0;
    idle_inputs();
    #12;
    apply_reset();

    run_cmd(10'h040, 3, 0, 1, 6'h10, 2, 0, -1, 0, -1);  // single row, arid 0
    run_cmd(10'h100, 1, 2, 3, 6'h20, 1, 1, -1, 0, -1);  // multi-row, gapped beats, arid 1
    run_cmd(10'h080, 0, 1, 2, 6'h05, 0, 0, 1, 0, -1);   // error on second beat
    run_cmd(10'h3C0, 3, 4, 1, 6'h3E, 0, 0, -1, 0, -1);  // buffer address wrap
    run_cmd(10'h000, 2, 0, 0, 6'h00, 0, 0, -1, 0, -1);  // zero rows
    run_cmd(10'h200, 3, 0, 1, 6'h30, 1, 0, -1, 0, 2);   // reset after 2 of 4 beats
    run_cmd(10'h040, 3, 1, 1, 6'h10, 0, 2, -1, 0, -1);  // normal after reset, arid 0

    for (int n = 0; n < 25; n++) begin
      run_cmd(AW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), BW'($urandom), int'($urandom_range(0, 3)), 2,
              -1, 1, -1);
    end

    repeat (6) @(posedge clk);
    #1;
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_ar_drained", exp_ar.size(), 0);
    chk("final_idle", ld_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
